// File: rtl/sample_playback_ctrl.sv
// Small generic FIFO: head visible combinationally (zero read latency), synchronous flush.
// Backpressure: a write into a full FIFO is dropped unless a read frees a slot in the same cycle.
module fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_rdy,
  output logic          rd_vld,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_fire;

  assign rd_vld  = (count != '0);
  assign rd_fire = rd_vld & rd_rdy;
  assign wr_fire = wr_vld & ((count != CW'(DEPTH)) | rd_fire);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_fire && !flush) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap by overflow, so DEPTH must be a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_fire) - CW'(rd_fire);
    end
  end
endmodule

// Streams base_addr..base_addr+length-1 (mod DEPTH) from a 1-bit RAM; first sample two cycles after start.
// Backpressure: reads are issued only while FIFO + in-flight stays within 2, so a stall never drops data.
module sample_playback_ctrl #(
  parameter int ADDR_W = 25,
  parameter int DEPTH  = 16000000,
  parameter int WRAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_data,
  output logic              sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt
);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_LO = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q, len_q;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic              inflight, inflight_nxt;
  logic              done_nxt;
  logic [WRAP_W-1:0] wrap_nxt;

  logic [ADDR_W-1:0] cur_base, cur_len, cur_idx;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] addr_calc;
  logic              last;
  logic              issue, capture, flush;
  logic              pop;
  logic [1:0]        fifo_cnt;
  logic              fifo_head;
  logic [2:0]        pending;

  // The accepting start cycle issues index 0 straight from the live inputs.
  assign cur_base  = (state == IDLE) ? base_addr : base_q;
  assign cur_len   = (state == IDLE) ? length    : len_q;
  assign cur_idx   = (state == IDLE) ? '0        : idx;
  assign addr_sum  = {1'b0, cur_base} + {1'b0, cur_idx};
  assign addr_calc = cur_base + cur_idx - ((addr_sum >= DEPTH_W) ? DEPTH_LO : '0);
  assign last      = (cur_idx == cur_len - ADDR_W'(1));

  assign pop        = sample_valid & sample_ready;
  assign pending    = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign busy       = (state != IDLE);
  assign sample_out = sample_valid & fifo_head;

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    ram_addr_nxt = ram_addr;
    inflight_nxt = 1'b0;
    done_nxt     = 1'b0;
    wrap_nxt     = wrap_cnt;
    issue        = 1'b0;
    capture      = 1'b0;
    flush        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture  = 1'b1;
          wrap_nxt = '0;
          if (length == '0) begin
            done_nxt = 1'b1;
          end else begin
            issue     = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          flush     = 1'b1;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end else if (pending < 3'd2) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (stop) begin
          flush     = 1'b1;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end else if (pending == 3'd0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (issue) begin
      ram_addr_nxt = addr_calc;
      inflight_nxt = 1'b1;
      if (last) begin
        idx_nxt = '0;
        if (loop_en) begin
          if (wrap_nxt != '1) wrap_nxt = wrap_nxt + WRAP_W'(1);
        end else begin
          state_nxt = DRAIN;
        end
      end else begin
        idx_nxt = cur_idx + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ram_addr <= '0;
      idx      <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
      wrap_cnt <= '0;
      base_q   <= '0;
      len_q    <= '0;
    end else begin
      state    <= state_nxt;
      ram_addr <= ram_addr_nxt;
      idx      <= idx_nxt;
      inflight <= inflight_nxt;
      done     <= done_nxt;
      wrap_cnt <= wrap_nxt;
      if (capture) begin
        base_q <= base_addr;
        len_q  <= length;
      end
    end
  end

  fifo #(
    .W     (1),
    .DEPTH (2)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .wr_vld (inflight & ~flush),
    .wr_dat (ram_data),
    .rd_rdy (sample_ready),
    .rd_vld (sample_valid),
    .rd_dat (fifo_head),
    .count  (fifo_cnt)
  );
endmodule

// File: tb/tb_sample_playback_ctrl.sv
// Scoreboarded bench for sample_playback_ctrl: directed playbacks against a fixed 256-bit RAM image.
module tb_sample_playback_ctrl;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int WRAP_W = 3;
  localparam logic [255:0] ROM =
    256'h3C5A9E17_E4D815C7_2B6F0A93_D1E47C58_9A3F0E61_5D27C8B4_7E2A39D4_6C1F54B2;

  logic              clk = 1'b0;
  logic              rst, start, stop, loop_en;
  logic [ADDR_W-1:0] base_addr, length;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic              sample_out, sample_valid, sample_ready;
  logic              busy, done;
  logic [WRAP_W-1:0] wrap_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_q[$];
  bit stall_prev = 1'b0;
  bit stall_val  = 1'b0;
  bit exp_bit;
  bit seen;

  sample_playback_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WRAP_W (WRAP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .base_addr    (base_addr),
    .length       (length),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done),
    .wrap_cnt     (wrap_cnt)
  );

  assign ram_data = ROM[ram_addr];

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_addr(input int a);
    exp_q.push_back(ROM[a]);
  endtask

  task automatic wait_done(input string name, input int budget);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(name, seen, 1);
  endtask

  // Monitor: every transfer pops the scoreboard; a stalled sample must hold its value.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && sample_valid) check("stall_stable", sample_out, stall_val);
      if (sample_valid && sample_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_sample: got %0d, expected no sample (t=%0t)", sample_out, $time);
        end else begin
          exp_bit = exp_q.pop_front();
          check("sample", sample_out, exp_bit);
        end
      end
      stall_prev = sample_valid && !sample_ready;
      stall_val  = sample_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    static int addr_tab[10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    static logic [11:0] rdy_pat = 12'b1100_0110_1001;

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    base_addr = '0; length = '0; sample_ready = 1'b1;
    tick(); tick();
    check("rst_ram_addr", ram_addr, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap_cnt, 0);
    rst = 1'b0;
    tick();

    // base 100, length 4: latency, back-to-back samples, done timing; late start/inputs ignored
    base_addr = 8'd100; length = 8'd4; loop_en = 1'b0;
    for (int a = 100; a <= 103; a++) push_addr(a);
    start = 1'b1;
    tick();
    base_addr = 8'd50; length = 8'd9;
    check("a_first_addr", ram_addr, 100);
    check("a_busy", busy, 1);
    check("a_valid_t1", sample_valid, 0);
    tick();
    start = 1'b0;
    check("a_valid_t2", sample_valid, 1);
    tick(); tick(); tick();
    check("a_valid_t5", sample_valid, 1);
    check("a_done_t5", done, 0);
    tick();
    check("a_done_t6", done, 1);
    check("a_busy_t6", busy, 0);
    check("a_valid_t6", sample_valid, 0);
    tick();
    check("a_done_pulse", done, 0);
    check("a_drained", exp_q.size(), 0);

    // address wrap at DEPTH; start with stop in IDLE is accepted
    base_addr = 8'd198; length = 8'd4;
    push_addr(198); push_addr(199); push_addr(0); push_addr(1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("b_addr0", ram_addr, 198);
    tick(); check("b_addr1", ram_addr, 199);
    tick(); check("b_addr2", ram_addr, 0);
    tick(); check("b_addr3", ram_addr, 1);
    wait_done("b_done_seen", 20);
    check("b_drained", exp_q.size(), 0);

    // looping pass of 3 with no gaps; stop holds wrap_cnt and suppresses done
    base_addr = 8'd0; length = 8'd3; loop_en = 1'b1;
    for (int p = 0; p < 3; p++) for (int a = 0; a < 3; a++) push_addr(a);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      check("c_loop_addr", ram_addr, addr_tab[n-1]);
      check("c_wrap", wrap_cnt, n / 3);
      if (n < 10) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("c_stop_busy", busy, 0);
    check("c_stop_valid", sample_valid, 0);
    check("c_stop_wrap_held", wrap_cnt, 3);
    check("c_stop_no_done", done, 0);
    check("c_drained", exp_q.size(), 0);

    // length 1 looping: wrap_cnt saturates at all-ones
    base_addr = 8'd5; length = 8'd1; loop_en = 1'b1;
    for (int k = 0; k < 8; k++) push_addr(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 9; n++) begin
      if (n == 6) check("d_wrap6", wrap_cnt, 6);
      tick();
    end
    check("d_wrap_sat", wrap_cnt, 7);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop_en = 1'b0;
    check("d_wrap_held", wrap_cnt, 7);
    check("d_drained", exp_q.size(), 0);

    // length 8 with a stuttering consumer
    base_addr = 8'd0; length = 8'd8;
    for (int a = 0; a < 8; a++) push_addr(a);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("e_wrap_cleared", wrap_cnt, 0);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      sample_ready = rdy_pat[k % 12];
      tick();
    end
    check("e_done_seen", seen, 1);
    check("e_busy", busy, 0);
    check("e_drained", exp_q.size(), 0);
    sample_ready = 1'b1;
    tick();

    // stop after two transfers, then a zero-length start
    base_addr = 8'd40; length = 8'd6;
    push_addr(40); push_addr(41);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    stop = 1'b1; sample_ready = 1'b0;
    tick();
    stop = 1'b0;
    check("f_stop_busy", busy, 0);
    check("f_stop_valid", sample_valid, 0);
    check("f_stop_no_done", done, 0);
    tick();
    check("f_no_done_later", done, 0);
    sample_ready = 1'b1;
    length = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f_zero_done", done, 1);
    check("f_zero_busy", busy, 0);
    check("f_zero_valid", sample_valid, 0);
    tick();
    check("f_zero_done_pulse", done, 0);
    check("f_zero_valid2", sample_valid, 0);
    check("f_drained", exp_q.size(), 0);

    // reset mid-run with stalled samples and start held alongside reset
    base_addr = 8'd60; length = 8'd1; loop_en = 1'b1; sample_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("g_valid_before_rst", sample_valid, 1);
    check("g_wrap_before_rst", wrap_cnt, 2);
    rst = 1'b1; start = 1'b1;
    tick();
    check("g_rst_ram_addr", ram_addr, 0);
    check("g_rst_valid", sample_valid, 0);
    check("g_rst_sample_out", sample_out, 0);
    check("g_rst_busy", busy, 0);
    check("g_rst_done", done, 0);
    check("g_rst_wrap", wrap_cnt, 0);
    rst = 1'b0; start = 1'b0; loop_en = 1'b0; sample_ready = 1'b1;
    tick();
    check("g_start_ignored", busy, 0);
    check("g_post_valid", sample_valid, 0);
    check("g_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
